// File: rtl/wb_stage.sv
// Write-back stage: register-file write formatting, HI/LO, CP0 Status/Cause/EPC,
// and the syscall/eret redirect with a fixed squash window for younger instructions.
module wb_stage #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0800,
    parameter int          FLUSH_DEPTH  = 3,
    parameter logic [4:0]  SYSCALL_CODE = 5'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemtoReg,
    input  logic        RegWr,
    input  logic        link,
    input  logic        LB,
    input  logic        LBU,
    input  logic        mult,
    input  logic        mfhi,
    input  logic        mflo,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mfc0,
    input  logic        mtc0,
    input  logic        syscall,
    input  logic        eret,
    input  logic [31:0] Dout,
    input  logic [31:0] Result,
    input  logic [31:0] PC,
    input  logic [4:0]  rw,
    input  logic [63:0] mult_Result,
    input  logic [4:0]  cpnum,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        squashing
);

    // Counter is at least 2 bits wide so the default depth of 3 fits.
    localparam int            CW = (FLUSH_DEPTH < 4) ? 2 : $clog2(FLUSH_DEPTH + 1);
    localparam logic [CW-1:0] FD = CW'(FLUSH_DEPTH);

    logic [CW-1:0] cnt;
    logic          take_sys;
    logic          take_eret;
    logic [7:0]    lane;
    logic [31:0]   load_data;
    logic [31:0]   cp0_rd;

    assign squashing = (cnt != '0);
    // syscall beats eret; nothing is taken inside the squash window or during reset.
    assign take_sys  = syscall & ~squashing & ~reset;
    assign take_eret = eret & ~syscall & ~squashing & ~reset;
    assign redirect  = take_sys | take_eret;
    assign rf_we     = RegWr & (rw != 5'd0) & ~squashing;
    assign rf_waddr  = rw;

    // Redirect target; eret uses the EPC value before this edge's update.
    always_comb begin
        redirect_pc = 32'd0;
        if (take_sys)
            redirect_pc = EXC_VECTOR;
        else if (take_eret)
            redirect_pc = epc;
    end

    // Load formatting, CP0 read mux and write-data priority select.
    always_comb begin
        lane = Dout[7:0];
        case (Result[1:0])
            2'd0: lane = Dout[7:0];
            2'd1: lane = Dout[15:8];
            2'd2: lane = Dout[23:16];
            2'd3: lane = Dout[31:24];
            default: lane = Dout[7:0];
        endcase
        if (LB)
            load_data = {{24{lane[7]}}, lane};
        else if (LBU)
            load_data = {24'd0, lane};
        else
            load_data = Dout;

        case (cpnum)
            5'd12:   cp0_rd = status;
            5'd13:   cp0_rd = cause;
            5'd14:   cp0_rd = epc;
            default: cp0_rd = 32'd0;
        endcase

        if (link)
            rf_wdata = PC + 32'd4;
        else if (mfc0)
            rf_wdata = cp0_rd;
        else if (mfhi)
            rf_wdata = hi;
        else if (mflo)
            rf_wdata = lo;
        else if (MemtoReg)
            rf_wdata = load_data;
        else
            rf_wdata = Result;
    end

    // Architectural state: HI/LO, CP0 and the squash down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi     <= 32'd0;
            lo     <= 32'd0;
            status <= 32'd0;
            cause  <= 32'd0;
            epc    <= 32'd0;
            cnt    <= '0;
        end else begin
            if (!squashing) begin
                if (mult) begin
                    hi <= mult_Result[63:32];
                    lo <= mult_Result[31:0];
                end else begin
                    if (mthi) hi <= Result;
                    if (mtlo) lo <= Result;
                end
                if (mtc0) begin
                    case (cpnum)
                        5'd12:   status     <= Result;
                        5'd13:   cause[9:8] <= Result[9:8];
                        5'd14:   epc        <= Result;
                        default: ;
                    endcase
                end
                // Exception bookkeeping comes last so it overrides a same-cycle mtc0.
                if (take_sys) begin
                    cause[6:2] <= SYSCALL_CODE;
                    status[1]  <= 1'b1;
                    if (!status[1]) epc <= PC;
                end else if (take_eret) begin
                    status[1] <= 1'b0;
                end
            end
            if (redirect)
                cnt <= FD;
            else if (squashing)
                cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expectations queued when a step is driven,
// popped and compared on the following negedge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemtoReg, RegWr, link, LB, LBU;
    logic        mult, mfhi, mflo, mthi, mtlo, mfc0, mtc0, syscall, eret;
    logic [31:0] Dout, Result, PC;
    logic [4:0]  rw, cpnum;
    logic [63:0] mult_Result;
    logic        rf_we, redirect, squashing;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, hi, lo, status, cause, epc, redirect_pc;

    wb_stage dut (
        .clk(clk), .reset(reset),
        .MemtoReg(MemtoReg), .RegWr(RegWr), .link(link), .LB(LB), .LBU(LBU),
        .mult(mult), .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
        .mfc0(mfc0), .mtc0(mtc0), .syscall(syscall), .eret(eret),
        .Dout(Dout), .Result(Result), .PC(PC), .rw(rw),
        .mult_Result(mult_Result), .cpnum(cpnum),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .hi(hi), .lo(lo), .status(status), .cause(cause), .epc(epc),
        .redirect(redirect), .redirect_pc(redirect_pc), .squashing(squashing)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty obs=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic clr();
        MemtoReg = 0; RegWr = 0; link = 0; LB = 0; LBU = 0;
        mult = 0; mfhi = 0; mflo = 0; mthi = 0; mtlo = 0;
        mfc0 = 0; mtc0 = 0; syscall = 0; eret = 0;
        Dout = '0; Result = '0; PC = '0; rw = '0; mult_Result = '0; cpnum = '0;
    endtask

    // Advance to just after the next posedge, where new stimulus is driven.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        next();
        // Reset state
        push("rst_hi", 0); push("rst_lo", 0); push("rst_status", 0);
        push("rst_cause", 0); push("rst_epc", 0); push("rst_squash", 0);
        push("rst_redirect", 0);
        @(negedge clk);
        pop_chk(hi); pop_chk(lo); pop_chk(status);
        pop_chk(cause); pop_chk(epc); pop_chk(squashing); pop_chk(redirect);

        // Byte loads from lane 2
        next();
        reset = 1'b0;
        RegWr = 1; rw = 5; MemtoReg = 1; LB = 1;
        Dout = 32'h12F4_5678; Result = 32'h1001_0002;
        push("lb_data", 32'hFFFF_FFF4); push("lb_we", 1); push("lb_waddr", 5);
        @(negedge clk);
        pop_chk(rf_wdata); pop_chk(rf_we); pop_chk(rf_waddr);

        next();
        LB = 0; LBU = 1;
        push("lbu_data", 32'h0000_00F4);
        @(negedge clk);
        pop_chk(rf_wdata);

        next();
        rw = 0;
        push("rw0_we", 0);
        @(negedge clk);
        pop_chk(rf_we);

        next();
        LBU = 0; rw = 6; Result = 32'h1001_0001;
        push("lw_data", 32'h12F4_5678);
        @(negedge clk);
        pop_chk(rf_wdata);

        // mult then mfhi / mtlo / mflo
        next();
        clr();
        mult = 1; mult_Result = 64'h0000_0001_FFFF_FFFE;
        push("mult_redirect", 0);
        @(negedge clk);
        pop_chk(redirect);

        next();
        clr();
        mfhi = 1; RegWr = 1; rw = 8;
        push("mfhi_data", 1); push("mult_lo", 32'hFFFF_FFFE);
        @(negedge clk);
        pop_chk(rf_wdata); pop_chk(lo);

        next();
        clr();
        mtlo = 1; Result = 7;
        @(negedge clk);

        next();
        clr();
        mflo = 1; RegWr = 1; rw = 9;
        push("mtlo_lo", 7); push("mtlo_hi", 1); push("mflo_data", 7);
        @(negedge clk);
        pop_chk(lo); pop_chk(hi); pop_chk(rf_wdata);

        // syscall from a clean status
        next();
        clr();
        syscall = 1; PC = 32'h0000_3010;
        push("sys_redirect", 1); push("sys_pc", 32'h800);
        @(negedge clk);
        pop_chk(redirect); pop_chk(redirect_pc);

        // Squash window: writes, HI update and an eret are all suppressed.
        for (int i = 0; i < 3; i++) begin
            next();
            clr();
            RegWr = 1; rw = 5; eret = 1; mthi = 1; Result = 32'hAAAA_5555;
            push("win_squash", 1); push("win_we", 0); push("win_redirect", 0);
            push("win_rpc", 0);
            @(negedge clk);
            pop_chk(squashing); pop_chk(rf_we); pop_chk(redirect); pop_chk(redirect_pc);
        end

        next();
        clr();
        push("post_squash", 0); push("sys_epc", 32'h3010); push("sys_cause", 32'h20);
        push("sys_status", 2); push("win_hi", 1);
        @(negedge clk);
        pop_chk(squashing); pop_chk(epc); pop_chk(cause); pop_chk(status); pop_chk(hi);

        // eret after the window
        next();
        eret = 1;
        push("eret_redirect", 1); push("eret_pc", 32'h3010);
        @(negedge clk);
        pop_chk(redirect); pop_chk(redirect_pc);

        next();
        push("eret2_redirect", 0); push("eret_exl", 0);
        @(negedge clk);
        pop_chk(redirect); pop_chk(status);

        next();
        eret = 0;
        next();
        next();
        push("eret_done", 0);
        @(negedge clk);
        pop_chk(squashing);

        // Set EXL via mtc0, then a masked Cause write.
        next();
        clr();
        mtc0 = 1; cpnum = 12; Result = 2;
        @(negedge clk);

        next();
        clr();
        mtc0 = 1; cpnum = 13; Result = 32'hFFFF_FFFF;
        @(negedge clk);

        next();
        clr();
        mfc0 = 1; cpnum = 12; RegWr = 1; rw = 3;
        push("mtc0_status", 2); push("mfc0_data", 2); push("mtc0_cause", 32'h320);
        @(negedge clk);
        pop_chk(status); pop_chk(rf_wdata); pop_chk(cause);

        // Nested syscall together with eret: syscall wins, EPC is kept.
        next();
        clr();
        syscall = 1; eret = 1; PC = 32'h0000_4000;
        push("both_redirect", 1); push("both_pc", 32'h800);
        @(negedge clk);
        pop_chk(redirect); pop_chk(redirect_pc);

        next();
        clr();
        push("nest_epc", 32'h3010); push("nest_status", 2); push("nest_squash", 1);
        @(negedge clk);
        pop_chk(epc); pop_chk(status); pop_chk(squashing);

        // Reset in the 2nd squash cycle.
        next();
        reset = 1;
        @(negedge clk);

        next();
        reset = 0;
        link = 1; PC = 32'h100; RegWr = 1; rw = 31;
        push("rr_squash", 0); push("rr_hi", 0); push("rr_lo", 0);
        push("rr_status", 0); push("rr_cause", 0); push("rr_epc", 0);
        push("link_data", 32'h104); push("link_we", 1);
        @(negedge clk);
        pop_chk(squashing); pop_chk(hi); pop_chk(lo);
        pop_chk(status); pop_chk(cause); pop_chk(epc);
        pop_chk(rf_wdata); pop_chk(rf_we);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_left obs=%0d exp=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
